mem_bus_arbiter: RTL
====================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have port clock, input, 1; system clock, all state on its rising edge.
REQ-002 SHALL have port reset, input, 1; asynchronous, active-high reset.
REQ-003 SHALL have CPU ports: cpu_addr in 32, cpu_wdata in 32, cpu_size in 2, cpu_write in 1, cpu_rdata out 32, cpu_pause out 1 (CPU holds all outputs stable while paused).
REQ-004 SHALL have DMA ports: dma_req in 1 (held for whole burst), dma_gnt out 1, dma_addr in 32, dma_wdata in 32, dma_size in 2, dma_write in 1, dma_rdata out 32, dma_pause out 1.
REQ-005 SHALL have memory-bus ports: mem_addr out 32, mem_wdata out 32, mem_size out 2, mem_write out 1, mem_rdata in 32 (valid one cycle after address), mem_pause in 1 (high the cycle after any accepted write).

Function
REQ-006 SHALL implement FSM states CPU_OWN, DMA_OWN, HANDOVER; owner muxing decoded from the registered state only.
REQ-007 CPU_OWN: mem_* driven from cpu_*; dma_gnt=0, dma_pause=1.
REQ-008 CPU_OWN with dma_req=1: cpu_pause=1, mem_write forced 0 that cycle; next state HANDOVER with target DMA.
REQ-009 DMA_OWN with dma_req=1: mem_* driven from dma_*; dma_gnt=1, cpu_pause=1.
REQ-010 DMA_OWN with dma_req=0: dma_gnt=0, dma_pause=1, mem_write forced 0; next state HANDOVER with target CPU.
REQ-011 HANDOVER: mem_write=0, cpu_pause=1, dma_pause=1, dma_gnt=0; lasts exactly one cycle unless mem_pause=1, in which case it holds until mem_pause=0; then moves to target state.
REQ-012 HANDOVER target SHALL be re-evaluated on exit: target DMA but dma_req=0 -> CPU_OWN; target CPU but dma_req=1 -> DMA_OWN.
REQ-013 Owner pause: in owning state, owner's pause = mem_pause.
REQ-014 While mem_pause=1, mem_write SHALL be forced 0 (no back-to-back write acceptance).
REQ-015 SHALL register mem_wdata each cycle mem_write=1 into wdata_hold; while mem_pause=1, mem_wdata SHALL equal wdata_hold regardless of owner.
REQ-016 SHALL register rd_owner (CPU/DMA/NONE) each cycle: owner if owning state and mem_write=0 and mem_pause=0, else NONE.
REQ-017 cpu_rdata = mem_rdata when rd_owner=CPU else 32'd0; dma_rdata likewise for DMA.
REQ-018 Read latency SHALL be exactly one cycle from address presentation; write occupies two cycles (accept + mem_pause).
REQ-019 DMA has strict priority: a CPU access in the same cycle dma_req rises SHALL NOT be issued.
REQ-020 mem_size SHALL follow owner's size; in HANDOVER it SHALL equal the last driven value (registered).

Reset
REQ-021 On reset: state CPU_OWN, handover target CPU, rd_owner NONE, wdata_hold 0, registered size 0.
REQ-022 Outputs during reset: dma_gnt 0, dma_pause 1, cpu_pause 0, mem_write 0, cpu_rdata 0, dma_rdata 0.
REQ-023 Reset asserted mid-burst or mid-write SHALL return to CPU_OWN immediately with no memory write issued after assertion.

Structure
REQ-024 Shared package gba_mem_pkg SHALL hold the state enum, owner enum (CPU, DMA, NONE) and MEM_SIZE_BYTE/HALF/WORD constants.
REQ-025 Single module; no sub-module; instantiated in front of the memory top bus port.

Verification
REQ-026 CPU read 0x0300_0010 in CPU_OWN -> mem_addr=0x0300_0010 same cycle; cpu_rdata=mem_rdata next cycle; dma_rdata=0.
REQ-027 CPU write 0x0600_0000=0xDEADBEEF, dma_req rises next cycle -> cycle2 mem_pause=1, mem_wdata=0xDEADBEEF, mem_write=0; HANDOVER held until mem_pause=0; dma_gnt=1 one cycle later.
REQ-028 dma_req high, DMA 4 word writes to 0x0700_0000..0x0700_000C -> mem_write pulses every other cycle, dma_pause mirrors mem_pause, cpu_pause=1 throughout.
REQ-029 dma_req drops after DMA read 0x0500_0004 -> dma_rdata valid in HANDOVER cycle, then CPU_OWN, cpu_pause=0; cpu_rdata=0 during HANDOVER.
REQ-030 dma_req pulses 1 cycle in CPU_OWN -> HANDOVER, then CPU_OWN (REQ-012); no dma_gnt; no write issued.
REQ-031 Reset asserted during DMA write pause -> state CPU_OWN, mem_write=0, dma_gnt=0 same cycle; next CPU access issued normally after release.

Source files
------------

// File: rtl/gba_mem_pkg.sv
// gba_mem_pkg: shared types and constants for the GBA memory bus arbiter.
// Contents: arbiter state enum, bus owner enum, mem_size encodings.
package gba_mem_pkg;

    typedef enum logic [1:0] {
        CPU_OWN  = 2'd0,
        DMA_OWN  = 2'd1,
        HANDOVER = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_CPU  = 2'd0,
        OWN_DMA  = 2'd1,
        OWN_NONE = 2'd2
    } owner_t;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
    localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between the CPU and a DMA engine.
// Ports:
//   clock, reset            - rising-edge clock, asynchronous active-high reset
//   cpu_*                   - CPU access request, read data and pause
//   dma_req/dma_gnt, dma_*  - DMA burst request/grant, access, read data and pause
//   mem_*                   - shared memory bus (read data one cycle after address,
//                             mem_pause high the cycle after an accepted write)
module mem_bus_arbiter
    import gba_mem_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_write,
    output logic [31:0] cpu_rdata,
    output logic        cpu_pause,
    input  logic        dma_req,
    output logic        dma_gnt,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [1:0]  dma_size,
    input  logic        dma_write,
    output logic [31:0] dma_rdata,
    output logic        dma_pause,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    input  logic        mem_pause
);

    state_t      state_q, state_d;
    owner_t      target_q, target_d;
    owner_t      rd_owner_q, rd_owner_d;
    logic [31:0] wdata_hold_q, wdata_hold_d;
    logic [1:0]  size_q, size_d;
    logic        in_cpu, in_dma, in_ho, use_dma;

    always_comb begin
        in_cpu       = state_q == CPU_OWN;
        in_dma       = state_q == DMA_OWN;
        in_ho        = state_q == HANDOVER;
        // During handover the bus already presents the incoming owner's address.
        use_dma      = in_dma || (in_ho && target_q == OWN_DMA);
        mem_addr     = use_dma ? dma_addr : cpu_addr;
        mem_size     = in_ho ? size_q : (use_dma ? dma_size : cpu_size);
        // A rising dma_req blocks the CPU access in that same cycle; reset gates writes immediately.
        mem_write    = !reset && !mem_pause &&
                       (in_cpu ? (cpu_write && !dma_req) : (in_dma && dma_req && dma_write));
        mem_wdata    = mem_pause ? wdata_hold_q : (use_dma ? dma_wdata : cpu_wdata);
        cpu_pause    = !reset && (!in_cpu || dma_req || mem_pause);
        dma_gnt      = in_dma && dma_req;
        dma_pause    = !dma_gnt || mem_pause;
        cpu_rdata    = rd_owner_q == OWN_CPU ? mem_rdata : 32'd0;
        dma_rdata    = rd_owner_q == OWN_DMA ? mem_rdata : 32'd0;
        wdata_hold_d = mem_write ? mem_wdata : wdata_hold_q;
        size_d       = mem_size;
        rd_owner_d   = (in_cpu || in_dma) && !mem_write && !mem_pause ?
                       (in_dma ? OWN_DMA : OWN_CPU) : OWN_NONE;
        target_d     = in_cpu && dma_req  ? OWN_DMA :
                       in_dma && !dma_req ? OWN_CPU : target_q;
        // Handover exit re-evaluates dma_req, so a withdrawn request returns to the CPU.
        state_d      = in_cpu ? (dma_req ? HANDOVER : CPU_OWN) :
                       in_dma ? (dma_req ? DMA_OWN : HANDOVER) :
                       in_ho  ? (mem_pause ? HANDOVER : (dma_req ? DMA_OWN : CPU_OWN)) :
                       CPU_OWN;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= CPU_OWN;
            target_q     <= OWN_CPU;
            rd_owner_q   <= OWN_NONE;
            wdata_hold_q <= 32'd0;
            size_q       <= 2'd0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            rd_owner_q   <= rd_owner_d;
            wdata_hold_q <= wdata_hold_d;
            size_q       <= size_d;
        end
    end

endmodule
